// File: rtl/hit_resolver_if.sv
// Bus between the two player FSMs/hitbox generators and the hit resolver.
// The master drives player state and box corners; the slave returns health, hit, stun and KO status.
interface hit_resolver_if;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned HEALTH_W = 8;
  localparam int unsigned WIN_W    = 2;

  logic                new_round;
  logic [STATE_W-1:0]  p1_state;
  logic [STATE_W-1:0]  p2_state;

  logic [COORD_W-1:0]  p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
  logic [COORD_W-1:0]  p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
  logic [COORD_W-1:0]  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
  logic [COORD_W-1:0]  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;

  logic [HEALTH_W-1:0] p1_health;
  logic [HEALTH_W-1:0] p2_health;
  logic                p1_hit;
  logic                p2_hit;
  logic                p1_stun;
  logic                p2_stun;
  logic                ko;
  logic [WIN_W-1:0]    winner;

  modport master (
    output new_round, p1_state, p2_state,
    output p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
    output p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
    output p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
    output p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
    input  p1_health, p2_health, p1_hit, p2_hit, p1_stun, p2_stun, ko, winner
  );

  modport slave (
    input  new_round, p1_state, p2_state,
    input  p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
    input  p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
    input  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
    input  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
    output p1_health, p2_health, p1_hit, p2_hit, p1_stun, p2_stun, ko, winner
  );
endinterface

// File: rtl/hit_resolver.sv
// Resolves hitbox/hurtbox contact between two fighters: applies damage, hitstun,
// one-hit-per-attack arming, and the FIGHT/KO round flow with winner latching.
module hit_resolver #(
  parameter int unsigned HEALTH_MAX  = 100,
  parameter int unsigned DAMAGE      = 10,
  parameter int unsigned STUN_CYCLES = 20
) (
  input logic          clk,
  input logic          rst,
  hit_resolver_if.slave bus
);
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned HEALTH_W = 8;
  localparam int unsigned WIN_W    = 2;
  localparam int unsigned STUN_W   = (STUN_CYCLES < 2) ? 1 : $clog2(STUN_CYCLES + 1);

  localparam logic [STATE_W-1:0]  ST_ATTACK_END = STATE_W'(4);
  localparam logic [HEALTH_W-1:0] HEALTH_FULL   = HEALTH_W'(HEALTH_MAX);
  localparam logic [STUN_W-1:0]   STUN_LOAD     = STUN_W'(STUN_CYCLES);

  typedef enum logic {
    FIGHT = 1'b0,
    KO    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [HEALTH_W-1:0] health1_q, health1_d;
  logic [HEALTH_W-1:0] health2_q, health2_d;
  logic [STUN_W-1:0]   stun_cnt1_q, stun_cnt1_d;
  logic [STUN_W-1:0]   stun_cnt2_q, stun_cnt2_d;
  logic                arm1_q, arm1_d;
  logic                arm2_q, arm2_d;
  logic                hit1_q, hit1_d;
  logic                hit2_q, hit2_d;
  logic                stun1_q, stun1_d;
  logic                stun2_q, stun2_d;
  logic                ko_q, ko_d;
  logic [WIN_W-1:0]    winner_q, winner_d;

  logic                p1_contact_c, p2_contact_c;
  logic                p1_strikes_c, p2_strikes_c;

  // Inclusive overlap of two intervals whose endpoints may arrive in either order.
  function automatic logic axis_overlap(input logic [COORD_W-1:0] a1, input logic [COORD_W-1:0] a2,
                                        input logic [COORD_W-1:0] b1, input logic [COORD_W-1:0] b2);
    logic [COORD_W-1:0] amin, amax, bmin, bmax;
    amin = (a1 < a2) ? a1 : a2;
    amax = (a1 < a2) ? a2 : a1;
    bmin = (b1 < b2) ? b1 : b2;
    bmax = (b1 < b2) ? b2 : b1;
    return (amin <= bmax) && (bmin <= amax);
  endfunction

  function automatic logic [HEALTH_W-1:0] take_damage(input logic [HEALTH_W-1:0] h);
    if (32'(h) > DAMAGE) return h - HEALTH_W'(DAMAGE);
    return '0;
  endfunction

  function automatic logic [STUN_W-1:0] drain(input logic [STUN_W-1:0] cnt);
    if (cnt != '0) return cnt - STUN_W'(1);
    return '0;
  endfunction

  // Geometric contact of each attacker's hitbox with the opponent's hurtbox.
  always_comb begin
    p1_contact_c = axis_overlap(bus.p1_hit_x1, bus.p1_hit_x2, bus.p2_hurt_x1, bus.p2_hurt_x2) &&
                   axis_overlap(bus.p1_hit_y1, bus.p1_hit_y2, bus.p2_hurt_y1, bus.p2_hurt_y2);
    p2_contact_c = axis_overlap(bus.p2_hit_x1, bus.p2_hit_x2, bus.p1_hurt_x1, bus.p1_hurt_x2) &&
                   axis_overlap(bus.p2_hit_y1, bus.p2_hit_y2, bus.p1_hurt_y1, bus.p1_hurt_y2);
  end

  // Only the attack-end state of an armed attacker lands during FIGHT; codes 6-15 never match.
  always_comb begin
    p1_strikes_c = (state_q == FIGHT) && arm1_q && (bus.p1_state == ST_ATTACK_END) && p1_contact_c;
    p2_strikes_c = (state_q == FIGHT) && arm2_q && (bus.p2_state == ST_ATTACK_END) && p2_contact_c;
  end

  // Next-state and next-output logic for the round FSM and per-player bookkeeping.
  always_comb begin
    state_d     = state_q;
    health1_d   = health1_q;
    health2_d   = health2_q;
    stun_cnt1_d = drain(stun_cnt1_q);
    stun_cnt2_d = drain(stun_cnt2_q);
    arm1_d      = arm1_q | (bus.p1_state != ST_ATTACK_END);
    arm2_d      = arm2_q | (bus.p2_state != ST_ATTACK_END);
    hit1_d      = 1'b0;
    hit2_d      = 1'b0;
    winner_d    = winner_q;

    case (state_q)
      FIGHT: begin
        if (p1_strikes_c) begin
          health2_d   = take_damage(health2_q);
          hit2_d      = 1'b1;
          stun_cnt2_d = STUN_LOAD;
          arm1_d      = 1'b0;
        end
        if (p2_strikes_c) begin
          health1_d   = take_damage(health1_q);
          hit1_d      = 1'b1;
          stun_cnt1_d = STUN_LOAD;
          arm2_d      = 1'b0;
        end
        // Winner bit 1 marks p1 down, bit 0 marks p2 down; a trade to zero gives 11.
        if ((health1_d == '0) || (health2_d == '0)) begin
          state_d  = KO;
          winner_d = {health1_d == '0, health2_d == '0};
        end
      end
      KO: begin
        if (bus.new_round) begin
          state_d     = FIGHT;
          health1_d   = HEALTH_FULL;
          health2_d   = HEALTH_FULL;
          stun_cnt1_d = '0;
          stun_cnt2_d = '0;
          arm1_d      = 1'b1;
          arm2_d      = 1'b1;
          winner_d    = '0;
        end
      end
      default: state_d = FIGHT;
    endcase

    ko_d    = (state_d == KO);
    stun1_d = (stun_cnt1_d != '0);
    stun2_d = (stun_cnt2_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FIGHT;
      health1_q   <= HEALTH_FULL;
      health2_q   <= HEALTH_FULL;
      stun_cnt1_q <= '0;
      stun_cnt2_q <= '0;
      arm1_q      <= 1'b1;
      arm2_q      <= 1'b1;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      stun1_q     <= 1'b0;
      stun2_q     <= 1'b0;
      ko_q        <= 1'b0;
      winner_q    <= '0;
    end else begin
      state_q     <= state_d;
      health1_q   <= health1_d;
      health2_q   <= health2_d;
      stun_cnt1_q <= stun_cnt1_d;
      stun_cnt2_q <= stun_cnt2_d;
      arm1_q      <= arm1_d;
      arm2_q      <= arm2_d;
      hit1_q      <= hit1_d;
      hit2_q      <= hit2_d;
      stun1_q     <= stun1_d;
      stun2_q     <= stun2_d;
      ko_q        <= ko_d;
      winner_q    <= winner_d;
    end
  end

  assign bus.p1_health = health1_q;
  assign bus.p2_health = health2_q;
  assign bus.p1_hit    = hit1_q;
  assign bus.p2_hit    = hit2_q;
  assign bus.p1_stun   = stun1_q;
  assign bus.p2_stun   = stun2_q;
  assign bus.ko        = ko_q;
  assign bus.winner    = winner_q;
endmodule

// File: tb/tb_hit_resolver.sv
// Self-checking bench for hit_resolver: directed scenarios plus randomized play,
// all compared cycle by cycle against an integer-level reference model.
module tb_hit_resolver;
  localparam int HMAX = 100;
  localparam int DMG  = 10;
  localparam int STUN = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hit_resolver_if bus ();

  hit_resolver #(.HEALTH_MAX(HMAX), .DAMAGE(DMG), .STUN_CYCLES(STUN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers describing the round.
  int m_h1, m_h2, m_st1, m_st2, m_win;
  bit m_arm1, m_arm2, m_ko, m_hit1, m_hit2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Two intervals touch when the larger of the lows does not exceed the smaller of the highs.
  function automatic bit ovl(input int a1, input int a2, input int b1, input int b2);
    return imax(imin(a1, a2), imin(b1, b2)) <= imin(imax(a1, a2), imax(b1, b2));
  endfunction

  function automatic int hurt(input int h);
    return (h > DMG) ? h - DMG : 0;
  endfunction

  // which: 0 p1 hitbox, 1 p1 hurtbox, 2 p2 hitbox, 3 p2 hurtbox.
  task automatic set_box(input int which, input int x1, input int x2, input int y1, input int y2);
    case (which)
      0: begin bus.p1_hit_x1 = 10'(x1);  bus.p1_hit_x2 = 10'(x2);  bus.p1_hit_y1 = 10'(y1);  bus.p1_hit_y2 = 10'(y2);  end
      1: begin bus.p1_hurt_x1 = 10'(x1); bus.p1_hurt_x2 = 10'(x2); bus.p1_hurt_y1 = 10'(y1); bus.p1_hurt_y2 = 10'(y2); end
      2: begin bus.p2_hit_x1 = 10'(x1);  bus.p2_hit_x2 = 10'(x2);  bus.p2_hit_y1 = 10'(y1);  bus.p2_hit_y2 = 10'(y2);  end
      default: begin bus.p2_hurt_x1 = 10'(x1); bus.p2_hurt_x2 = 10'(x2); bus.p2_hurt_y1 = 10'(y1); bus.p2_hurt_y2 = 10'(y2); end
    endcase
  endtask

  // Advance the model by one clock from the current inputs, then clock the DUT and compare.
  task automatic step();
    bit s12, s21;
    s12 = !m_ko && m_arm1 && (bus.p1_state == 4'd4) &&
          ovl(bus.p1_hit_x1, bus.p1_hit_x2, bus.p2_hurt_x1, bus.p2_hurt_x2) &&
          ovl(bus.p1_hit_y1, bus.p1_hit_y2, bus.p2_hurt_y1, bus.p2_hurt_y2);
    s21 = !m_ko && m_arm2 && (bus.p2_state == 4'd4) &&
          ovl(bus.p2_hit_x1, bus.p2_hit_x2, bus.p1_hurt_x1, bus.p1_hurt_x2) &&
          ovl(bus.p2_hit_y1, bus.p2_hit_y2, bus.p1_hurt_y1, bus.p1_hurt_y2);
    if (rst) begin
      m_h1 = HMAX; m_h2 = HMAX; m_st1 = 0; m_st2 = 0; m_win = 0;
      m_arm1 = 1; m_arm2 = 1; m_ko = 0; m_hit1 = 0; m_hit2 = 0;
    end else if (m_ko && bus.new_round) begin
      m_h1 = HMAX; m_h2 = HMAX; m_st1 = 0; m_st2 = 0; m_win = 0;
      m_arm1 = 1; m_arm2 = 1; m_ko = 0; m_hit1 = 0; m_hit2 = 0;
    end else begin
      m_hit1 = s21;
      m_hit2 = s12;
      m_st1  = s21 ? STUN : imax(m_st1 - 1, 0);
      m_st2  = s12 ? STUN : imax(m_st2 - 1, 0);
      if (s21) m_h1 = hurt(m_h1);
      if (s12) m_h2 = hurt(m_h2);
      m_arm1 = s12 ? 1'b0 : (m_arm1 || bus.p1_state != 4'd4);
      m_arm2 = s21 ? 1'b0 : (m_arm2 || bus.p2_state != 4'd4);
      if (!m_ko && (m_h1 == 0 || m_h2 == 0)) begin
        m_ko  = 1;
        m_win = (m_h1 == 0 ? 2 : 0) + (m_h2 == 0 ? 1 : 0);
      end
    end
    @(posedge clk);
    #1;
    check("p1_health", 32'(bus.p1_health), 32'(m_h1));
    check("p2_health", 32'(bus.p2_health), 32'(m_h2));
    check("p1_hit",    32'(bus.p1_hit),    32'(m_hit1));
    check("p2_hit",    32'(bus.p2_hit),    32'(m_hit2));
    check("p1_stun",   32'(bus.p1_stun),   32'(m_st1 != 0));
    check("p2_stun",   32'(bus.p2_stun),   32'(m_st2 != 0));
    check("ko",        32'(bus.ko),        32'(m_ko));
    check("winner",    32'(bus.winner),    32'(m_win));
  endtask

  task automatic do_reset();
    bus.p1_state  = 4'd0;
    bus.p2_state  = 4'd0;
    bus.new_round = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Mutually overlapping geometry: each hitbox reaches the other player's hurtbox.
  task automatic trade_geometry();
    set_box(0, 245, 323, 194, 227);
    set_box(3, 300, 353, 170, 320);
    set_box(2, 250, 310, 200, 220);
    set_box(1, 200, 260, 170, 320);
  endtask

  function automatic int rc();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 0;
    if (r == 1) return 1023;
    return int'($urandom_range(150, 330));
  endfunction

  initial begin
    int hits, stuns;
    rst = 1'b0;
    bus.new_round = 1'b0;
    bus.p1_state = 4'd0;
    bus.p2_state = 4'd0;
    trade_geometry();

    do_reset();
    check("rst_p1_health", 32'(bus.p1_health), 32'd100);
    check("rst_winner", 32'(bus.winner), 32'd0);

    // Single attack held three cycles lands exactly once with a 20-cycle stun.
    set_box(2, 900, 910, 900, 910);
    hits = 0; stuns = 0;
    bus.p1_state = 4'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      hits += int'(bus.p2_hit);
      stuns += int'(bus.p2_stun);
    end
    bus.p1_state = 4'd0;
    for (int i = 0; i < 25; i++) begin
      step();
      hits += int'(bus.p2_hit);
      stuns += int'(bus.p2_stun);
    end
    check("hold_health", 32'(bus.p2_health), 32'd90);
    check("hold_pulses", 32'(hits), 32'd1);
    check("hold_stun_len", 32'(stuns), 32'd20);

    // Same attack with the hurtbox out of reach.
    do_reset();
    set_box(3, 400, 453, 170, 320);
    hits = 0;
    bus.p1_state = 4'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      hits += int'(bus.p2_hit);
    end
    bus.p1_state = 4'd0;
    step();
    check("miss_health", 32'(bus.p2_health), 32'd100);
    check("miss_pulses", 32'(hits), 32'd0);

    // Reversed hurtbox corners, edges touching at x=300.
    do_reset();
    set_box(0, 245, 300, 194, 227);
    set_box(3, 353, 300, 170, 320);
    bus.p1_state = 4'd4;
    step();
    check("edge_health", 32'(bus.p2_health), 32'd90);
    check("edge_pulse", 32'(bus.p2_hit), 32'd1);
    bus.p1_state = 4'd0;
    step();

    // Trades down to a double KO, then further strikes are ignored.
    do_reset();
    trade_geometry();
    for (int i = 0; i < 9; i++) begin
      bus.p1_state = 4'd4; bus.p2_state = 4'd4; step();
      bus.p1_state = 4'd0; bus.p2_state = 4'd0; step();
    end
    check("trade_h1", 32'(bus.p1_health), 32'd10);
    check("trade_h2", 32'(bus.p2_health), 32'd10);
    bus.p1_state = 4'd4; bus.p2_state = 4'd4; step();
    check("draw_h1", 32'(bus.p1_health), 32'd0);
    check("draw_ko", 32'(bus.ko), 32'd1);
    check("draw_winner", 32'(bus.winner), 32'd3);
    bus.p1_state = 4'd0; bus.p2_state = 4'd0; step();
    bus.p1_state = 4'd4; bus.p2_state = 4'd4; step();
    check("ko_no_pulse", 32'(bus.p2_hit), 32'd0);
    check("ko_winner_hold", 32'(bus.winner), 32'd3);

    // P1 wins outright, then a new round restarts.
    do_reset();
    trade_geometry();
    bus.p2_state = 4'd0;
    for (int i = 0; i < 10; i++) begin
      bus.p1_state = 4'd4; step();
      bus.p1_state = 4'd0; step();
    end
    check("p1win_winner", 32'(bus.winner), 32'd1);
    check("p1win_ko", 32'(bus.ko), 32'd1);
    bus.new_round = 1'b1;
    step();
    bus.new_round = 1'b0;
    check("round_ko", 32'(bus.ko), 32'd0);
    check("round_h2", 32'(bus.p2_health), 32'd100);
    check("round_winner", 32'(bus.winner), 32'd0);

    // Reset coinciding with a strike while p1 is stunned.
    do_reset();
    trade_geometry();
    bus.p2_state = 4'd4; step();
    bus.p2_state = 4'd0; step();
    check("pre_rst_stun", 32'(bus.p1_stun), 32'd1);
    bus.p1_state = 4'd4;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_strike_h1", 32'(bus.p1_health), 32'd100);
    check("rst_strike_h2", 32'(bus.p2_health), 32'd100);
    check("rst_strike_stun", 32'(bus.p1_stun), 32'd0);
    check("rst_strike_pulse", 32'(bus.p2_hit), 32'd0);
    bus.p1_state = 4'd0;
    step();

    // Randomized play: clustered boxes, biased toward attack-end, occasional restart and reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) set_box(0, rc(), rc(), rc(), rc());
      if ($urandom_range(0, 3) == 0) set_box(1, rc(), rc(), rc(), rc());
      if ($urandom_range(0, 3) == 0) set_box(2, rc(), rc(), rc(), rc());
      if ($urandom_range(0, 3) == 0) set_box(3, rc(), rc(), rc(), rc());
      bus.p1_state  = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'($urandom_range(0, 15));
      bus.p2_state  = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'($urandom_range(0, 15));
      bus.new_round = ($urandom_range(0, 9) == 0);
      rst           = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
